// File: rtl/lc3b_types.sv
// Shared LC-3b types: memory arbiter state encoding and the captured request record
// that is handed downstream while an access is in flight.
package lc3b_types;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_A,
    BUSY_B
  } arb_state_t;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [1:0]  wmask;
    logic [15:0] addr;
    logic [15:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/arb_req_reg.sv
// Holds the granted request so the downstream access is immune to requester changes.
module arb_req_reg
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     clear,
  input  logic     load,
  input  mem_req_t d,
  output mem_req_t q
);

  always_ff @(posedge clk) begin
    if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between fetch (A, read-only) and MEM data (B, read/write).
// B has fixed priority; a starvation counter forces A through after STARVE_LIMIT B wins.
module mem_port_arbiter
  import lc3b_types::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 read_a,
  input  logic [15:0]          address_a,
  output logic                 resp_a,
  output logic [15:0]          rdata_a,
  input  logic                 read_b,
  input  logic                 write_b,
  input  logic [1:0]           wmask_b,
  input  logic [15:0]          address_b,
  input  logic [15:0]          wdata_b,
  output logic                 resp_b,
  output logic [15:0]          rdata_b,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [1:0]           mem_wmask,
  output logic [15:0]          mem_address,
  output logic [15:0]          mem_wdata,
  input  logic                 mem_resp,
  input  logic [15:0]          mem_rdata,
  input  logic                 conflict_count_reset,
  output logic [CNT_WIDTH-1:0] conflict_count
);

  localparam int STARVE_W = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  arb_state_t          state, state_next;
  logic [STARVE_W-1:0] starve_cnt, starve_next;
  mem_req_t            req_d, req_q;
  logic                load;
  logic                req_b;
  logic                busy;
  logic                conflict;

  assign req_b = read_b | write_b;
  assign busy  = (state != IDLE);

  arb_req_reg u_req_reg (
    .clk   (clk),
    .clear (reset),
    .load  (load),
    .d     (req_d),
    .q     (req_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      starve_cnt     <= '0;
      conflict_count <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
      if (conflict_count_reset) begin
        conflict_count <= '0;
      end else if (conflict) begin
        conflict_count <= conflict_count + CNT_WIDTH'(1);
      end
    end
  end

  // A only wins a contested IDLE cycle once B has had STARVE_LIMIT consecutive wins.
  always_comb begin
    state_next  = state;
    starve_next = starve_cnt;
    load        = 1'b0;
    req_d       = '0;
    unique case (state)
      IDLE: begin
        if (read_a && (!req_b || starve_cnt == STARVE_MAX)) begin
          state_next  = BUSY_A;
          starve_next = '0;
          load        = 1'b1;
          req_d.rd    = 1'b1;
          req_d.addr  = address_a;
        end else if (req_b) begin
          state_next  = BUSY_B;
          starve_next = read_a ? starve_cnt + STARVE_W'(1) : '0;
          load        = 1'b1;
          req_d.rd    = read_b & ~write_b;
          req_d.wr    = write_b;
          req_d.wmask = wmask_b;
          req_d.addr  = address_b;
          req_d.wdata = wdata_b;
        end
      end
      BUSY_A, BUSY_B: begin
        if (mem_resp) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign conflict = ((state == BUSY_A) && req_b) ||
                    ((state == BUSY_B) && read_a) ||
                    ((state == IDLE) && read_a && req_b);

  assign mem_read    = busy & req_q.rd;
  assign mem_write   = busy & req_q.wr;
  assign mem_wmask   = busy ? req_q.wmask : 2'b00;
  assign mem_address = busy ? req_q.addr : 16'h0000;
  assign mem_wdata   = busy ? req_q.wdata : 16'h0000;

  // A response coinciding with reset belongs to an aborted access and is swallowed.
  assign resp_a  = (state == BUSY_A) & mem_resp & ~reset;
  assign resp_b  = (state == BUSY_B) & mem_resp & ~reset;
  assign rdata_a = resp_a ? mem_rdata : 16'h0000;
  assign rdata_b = resp_b ? mem_rdata : 16'h0000;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by a random phase,
// all compared each cycle against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        read_a;
  logic [15:0] address_a;
  logic        resp_a;
  logic [15:0] rdata_a;
  logic        read_b;
  logic        write_b;
  logic [1:0]  wmask_b;
  logic [15:0] address_b;
  logic [15:0] wdata_b;
  logic        resp_b;
  logic [15:0] rdata_b;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_wmask;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic        conflict_count_reset;
  logic [15:0] conflict_count;

  int checks = 0;
  int errors = 0;

  // Model: who owns the port (0 none, 1 fetch, 2 data), the captured access, and counters.
  int          m_owner;
  logic        m_rd, m_wr;
  logic [1:0]  m_wmask;
  logic [15:0] m_addr, m_wdata;
  int          m_b_wins;
  int          m_cnt;
  string       grant_log;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_WIDTH(16)) dut (
    .clk                  (clk),
    .reset                (reset),
    .read_a               (read_a),
    .address_a            (address_a),
    .resp_a               (resp_a),
    .rdata_a              (rdata_a),
    .read_b               (read_b),
    .write_b              (write_b),
    .wmask_b              (wmask_b),
    .address_b            (address_b),
    .wdata_b              (wdata_b),
    .resp_b               (resp_b),
    .rdata_b              (rdata_b),
    .mem_read             (mem_read),
    .mem_write            (mem_write),
    .mem_wmask            (mem_wmask),
    .mem_address          (mem_address),
    .mem_wdata            (mem_wdata),
    .mem_resp             (mem_resp),
    .mem_rdata            (mem_rdata),
    .conflict_count_reset (conflict_count_reset),
    .conflict_count       (conflict_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic ra, input logic [15:0] aa, input logic rb,
                               input logic wb, input logic [1:0] mb, input logic [15:0] ab,
                               input logic [15:0] db, input logic mr, input logic [15:0] mrd,
                               input logic ccr, input logic rst);
    read_a = ra; address_a = aa; read_b = rb; write_b = wb; wmask_b = mb;
    address_b = ab; wdata_b = db; mem_resp = mr; mem_rdata = mrd;
    conflict_count_reset = ccr; reset = rst;
  endtask

  task automatic modelClear();
    m_owner = 0; m_rd = 0; m_wr = 0; m_wmask = 0; m_addr = 0; m_wdata = 0;
    m_b_wins = 0; m_cnt = 0;
  endtask

  // Compare every output with the model mid-cycle, then advance the model across the edge.
  task automatic checkOutput();
    logic busy, ea, eb, want_b, conf;
    @(negedge clk);
    busy = (m_owner != 0);
    ea = (m_owner == 1) && mem_resp && !reset;
    eb = (m_owner == 2) && mem_resp && !reset;
    chk("mem_read", 32'(mem_read), 32'(busy & m_rd));
    chk("mem_write", 32'(mem_write), 32'(busy & m_wr));
    chk("mem_wmask", 32'(mem_wmask), busy ? 32'(m_wmask) : 32'd0);
    chk("mem_address", 32'(mem_address), busy ? 32'(m_addr) : 32'd0);
    chk("mem_wdata", 32'(mem_wdata), busy ? 32'(m_wdata) : 32'd0);
    chk("resp_a", 32'(resp_a), 32'(ea));
    chk("resp_b", 32'(resp_b), 32'(eb));
    chk("rdata_a", 32'(rdata_a), ea ? 32'(mem_rdata) : 32'd0);
    chk("rdata_b", 32'(rdata_b), eb ? 32'(mem_rdata) : 32'd0);
    chk("conflict_count", 32'(conflict_count), 32'(m_cnt));
    if (resp_a === 1'b1) grant_log = {grant_log, "A"};
    if (resp_b === 1'b1) grant_log = {grant_log, "B"};

    want_b = read_b | write_b;
    conf = (m_owner == 1 && want_b) || (m_owner == 2 && read_a) || (m_owner == 0 && read_a && want_b);
    if (reset) begin
      modelClear();
    end else begin
      if (conflict_count_reset) m_cnt = 0;
      else if (conf) m_cnt = (m_cnt + 1) % 65536;
      if (m_owner == 0) begin
        if (read_a && (!want_b || m_b_wins == LIMIT)) begin
          m_owner = 1; m_b_wins = 0;
          m_rd = 1; m_wr = 0; m_wmask = 0; m_addr = address_a; m_wdata = 0;
        end else if (want_b) begin
          m_owner = 2;
          m_b_wins = read_a ? m_b_wins + 1 : 0;
          m_wr = write_b; m_rd = read_b && !write_b;
          m_wmask = wmask_b; m_addr = address_b; m_wdata = wdata_b;
        end
      end else if (mem_resp) begin
        m_owner = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int cnt0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    modelClear();
    grant_log = "";

    // Reset state
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_count", 32'(conflict_count), 32'd0);
    checkOutput();

    // 1: fetch read with a 3-cycle response delay
    applyStimulus(1, 16'h0040, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput();
    applyStimulus(0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("t1_mem_read", 32'(mem_read), 32'd1);
    chk("t1_mem_address", 32'(mem_address), 32'h0040);
    checkOutput();
    checkOutput();
    applyStimulus(0, 16'h0000, 0, 0, 0, 0, 0, 1, 16'hBEEF, 0, 0);
    #1;
    chk("t1_resp_a", 32'(resp_a), 32'd1);
    chk("t1_rdata_a", 32'(rdata_a), 32'hBEEF);
    chk("t1_resp_b", 32'(resp_b), 32'd0);
    checkOutput();

    // 2: data write
    applyStimulus(0, 0, 0, 1, 2'b10, 16'h1001, 16'h3400, 0, 0, 0, 0);
    checkOutput();
    applyStimulus(0, 0, 0, 0, 2'b00, 16'h0000, 16'h0000, 1, 16'h1234, 0, 0);
    #1;
    chk("t2_mem_write", 32'(mem_write), 32'd1);
    chk("t2_mem_read", 32'(mem_read), 32'd0);
    chk("t2_mem_wmask", 32'(mem_wmask), 32'h2);
    chk("t2_mem_wdata", 32'(mem_wdata), 32'h3400);
    chk("t2_resp_b", 32'(resp_b), 32'd1);
    checkOutput();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput();

    // 3: both ports held, memory answers in the first busy cycle
    grant_log = "";
    cnt0 = m_cnt;
    n = 0;
    while (grant_log.len() < 10 && n < 40) begin
      applyStimulus(1, 16'hAAAA, 1, 0, 0, 16'hBBBB, 0, (m_owner != 0), 16'h5A5A, 0, 0);
      checkOutput();
      n++;
    end
    chk("t3_order", 32'(grant_log == "BBBBABBBBA"), 32'd1);
    chk("t3_count", 32'(conflict_count), 32'((cnt0 + n) % 65536));

    // 4: data read whose requester changes after the grant
    applyStimulus(0, 0, 1, 0, 0, 16'h2222, 0, 0, 0, 0, 0);
    checkOutput();
    applyStimulus(0, 0, 0, 0, 0, 16'h9999, 0, 0, 0, 0, 0);
    #1;
    chk("t4_addr_hold", 32'(mem_address), 32'h2222);
    checkOutput();
    applyStimulus(0, 0, 0, 0, 0, 16'h9999, 0, 1, 16'h7777, 0, 0);
    #1;
    chk("t4_addr_hold2", 32'(mem_address), 32'h2222);
    chk("t4_resp_b", 32'(resp_b), 32'd1);
    checkOutput();

    // 5: reset during a fetch, with a response in the same cycle and one after
    applyStimulus(1, 16'h0101, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput();
    applyStimulus(0, 16'h0000, 1, 0, 0, 16'h0202, 0, 1, 16'hDEAD, 0, 1);
    #1;
    chk("t5_no_resp_a", 32'(resp_a), 32'd0);
    checkOutput();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 16'hDEAD, 0, 0);
    #1;
    chk("t5_mem_read", 32'(mem_read), 32'd0);
    chk("t5_mem_address", 32'(mem_address), 32'd0);
    chk("t5_count", 32'(conflict_count), 32'd0);
    chk("t5_late_resp", 32'(resp_a), 32'd0);
    checkOutput();

    // 6: clearing the conflict counter while a conflict is present
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 16'h0300, 1, 0, 0, 16'h0400, 0, (m_owner != 0), 0, 0, 0);
      checkOutput();
    end
    applyStimulus(1, 16'h0300, 1, 0, 0, 16'h0400, 0, (m_owner != 0), 0, 1, 0);
    checkOutput();
    chk("t6_clear", 32'(conflict_count), 32'd0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 16'h0300, 1, 0, 0, 16'h0400, 0, (m_owner != 0), 0, 0, 0);
      checkOutput();
    end
    chk("t6_resume", 32'(conflict_count), 32'd2);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 9) < 6, 16'($urandom), $urandom_range(0, 9) < 4,
                    $urandom_range(0, 9) < 3, 2'($urandom), 16'($urandom), 16'($urandom),
                    $urandom_range(0, 9) < 4, 16'($urandom),
                    $urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0);
      checkOutput();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single physical memory port between the fetch stage (port A, read-only) and the MEM stage data port (port B, read/write).
- Port B is the read_b/write_b/wmask_b/address_b/wdata_b/resp_b/rdata_b interface that mem_datapath drives.
- Each granted request is captured into internal registers before it goes downstream, so requester handshake changes cannot corrupt an in-flight access.
- Port B has fixed priority, with a starvation guard for fetch. A stall-conflict performance counter follows the existing counter style.

Parameters:
STARVE_LIMIT, 4, consecutive B grants allowed while A is waiting before A is forced ahead of B.
CNT_WIDTH, 16, width of conflict_count.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
read_a  in  1  fetch read request
address_a  in  16  fetch address
resp_a  out  1  fetch response strobe
rdata_a  out  16  fetch read data
read_b  in  1  data read request
write_b  in  1  data write request
wmask_b  in  2  byte write mask
address_b  in  16  data address
wdata_b  in  16  data write data
resp_b  out  1  data response strobe
rdata_b  out  16  data read data
mem_read  out  1  downstream read
mem_write  out  1  downstream write
mem_wmask  out  2  downstream byte mask
mem_address  out  16  downstream address
mem_wdata  out  16  downstream write data
mem_resp  in  1  downstream completion
mem_rdata  in  16  downstream read data
conflict_count_reset  in  1  clears conflict_count
conflict_count  out  CNT_WIDTH  cycles with a request waiting behind another access

Behaviour:
- States: IDLE, BUSY_A, BUSY_B. State register resets to IDLE.
- Registers: owner-request copies (rd, wr, wmask, addr, wdata), starve_cnt (3 bits minimum, sized to hold STARVE_LIMIT) and conflict_count. All reset to 0.
- Reset is synchronous and active-high. Asserting it mid-transaction:
  - aborts the access: state goes to IDLE and mem_read/mem_write are 0 from the next cycle;
  - any mem_resp arriving after that is ignored.
- Arbitration in IDLE, with req_b = read_b|write_b:
  - req_b only: grant B.
  - read_a only: grant A.
  - both, starve_cnt < STARVE_LIMIT: grant B, starve_cnt++.
  - both, starve_cnt == STARVE_LIMIT: grant A, starve_cnt cleared.
  - Any grant to A clears starve_cnt.
  - A B grant while read_a=0 also clears starve_cnt.
- On a grant:
  - The owner's signals are captured into the copy registers at the clock edge, and the state moves to BUSY_x.
  - For A, the captured values are rd=1, wr=0, wmask=0, wdata=0.
  - For B, if read_b and write_b are both 1, the write wins and rd is captured as 0.
- In BUSY_x:
  - mem_* outputs are driven only from the copy registers.
  - In IDLE, mem_read, mem_write, mem_wmask, mem_address and mem_wdata are all 0.
  - Issue latency: request seen in cycle N means mem_read/mem_write is asserted in cycle N+1.
- Completion:
  - When mem_resp=1 in BUSY_x, resp_x=1 in the same cycle (combinational) and rdata_x = mem_rdata.
  - The state returns to IDLE at that edge.
  - mem_resp in IDLE is ignored.
- Response outputs:
  - resp_a and resp_b are never both 1, and are 0 outside their BUSY state.
  - rdata_a and rdata_b are 0 when their resp is 0.
- Request handling:
  - A requester may drop or change its request while BUSY; the captured access still completes, and its resp pulse is still issued.
  - A requester that holds its request after resp is re-arbitrated as a new access in the following IDLE cycle.
  - Minimum occupancy: one IDLE cycle between back-to-back accesses.
- conflict_count:
  - Increments each cycle in which the non-owner port is requesting while in BUSY_x, and each IDLE cycle where both ports request.
  - Wraps at 2^CNT_WIDTH.
  - conflict_count_reset takes priority over the increment.

Decomposition:
- Shared package lc3b_types gets:
  - enum arb_state_t {IDLE, BUSY_A, BUSY_B};
  - struct mem_req_t {rd, wr, wmask, addr, wdata}.
- One natural sub-module: arb_req_reg, a load-enabled mem_req_t register with synchronous clear. It is instantiated once, and its load is asserted on the grant.

Test Plan:
1. read_a=1, address_a=16'h0040, mem_resp delayed 3 cycles (mem_rdata=16'hBEEF) -> mem_read rises 1 cycle after request with mem_address=16'h0040; resp_a=1 with rdata_a=16'hBEEF in the mem_resp cycle; resp_b stays 0.
2. write_b=1, address_b=16'h1001, wdata_b=16'h3400, wmask_b=2'b10 -> mem_write=1, mem_wmask=2'b10, mem_wdata=16'h3400, mem_read=0; resp_b pulses once.
3. read_a and read_b held continuously, 1-cycle mem latency -> B is granted 4 times, then A once, repeating. conflict_count increases every cycle.
4. read_b=1 granted, then read_b dropped and address_b changed the next cycle -> mem_address stays at the captured value; resp_b still pulses when mem_resp arrives.
5. reset asserted while in BUSY_A, with mem_resp asserted in the same cycle -> no resp_a; next cycle state is IDLE, all mem_* are 0, and conflict_count=0.
6. conflict_count_reset=1 while a conflict is present -> conflict_count=0 next cycle; the count resumes incrementing once the reset is deasserted.
